seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the pattern length in bits; the legal range is 2..8.
REQ-002 The block SHALL have parameter PATTERN, N bits wide, default 4'b1001, giving the target sequence; its MSB is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1; 1 selects overlapping detection and 0 selects non-overlapping detection.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port din, input, 1 bit: serial data bit.
REQ-008 Port din_vld, input, 1 bit: din is accepted only on rising edges where din_vld=1.
REQ-009 Port y, output, 1 bit: registered Moore match flag.
REQ-010 Port match_cnt, output, CNT_W bits: number of completed matches.

Function
REQ-011 The state SHALL be a match depth k in 0..N, held in ceil(log2(N+1)) bits; k is the number of pattern bits currently matched as a prefix.
REQ-012 In state k<N with an accepted bit b: if b==PATTERN[N-1-k], next state SHALL be k+1.
- Otherwise, next state SHALL be the longest proper prefix of PATTERN that is a suffix of (matched prefix, b), i.e. KMP failure semantics.
- No shortcut reset to 0 is allowed where a partial match survives.
REQ-013 In state N with OVERLAP=1, the next state SHALL be computed as in REQ-012, treating all N bits as matched and using the border of PATTERN.
REQ-014 In state N with OVERLAP=0, the next state SHALL be 1 if b==PATTERN[N-1], else 0.
REQ-015 y SHALL be 1 exactly when state==N; y is never combinationally dependent on din.
REQ-016 Latency: y SHALL rise on the edge that accepts the last pattern bit, i.e. 1 cycle after that bit is presented.
REQ-017 With din_vld=0 the state SHALL hold; y therefore stays high while stalled in state N.
REQ-018 Back-to-back matches, e.g. PATTERN=11 with OVERLAP=1 and a continuous stream of 1s, SHALL keep y high on consecutive cycles.
REQ-019 The next-state logic SHALL be derived from PATTERN and N at elaboration; no run-time pattern load.
REQ-020 Unreachable state encodings (above N) SHALL go to state 0 on the next edge, regardless of din_vld.

Reset
REQ-021 When reset=1 at a rising edge, the state SHALL become 0, y SHALL become 0 and match_cnt SHALL become 0.
REQ-022 Reset SHALL take priority over din_vld and din, including mid-pattern and while in state N.
REQ-023 Bits accepted before reset SHALL NOT contribute to any later match.

Configuration
REQ-024 With macro SEQ_DETECT_CNT_EN defined, match_cnt SHALL increment by 1 on each edge where an accepted bit moves the state into N, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 With SEQ_DETECT_CNT_EN undefined, match_cnt SHALL be tied to 0, no counter flops shall be built, and the port list is unchanged.

Verification
REQ-026 Default parameters, din_vld=1, stream 1,0,0,1,0,0,1 -> y high in the cycle after bit 4 and after bit 7; match_cnt=2 with SEQ_DETECT_CNT_EN.
REQ-027 OVERLAP=0, same stream -> y high only after bit 4; match_cnt=1.
REQ-028 Default parameters, stream 1,1,0,0,1 -> no false reset on the second 1 (state goes 1->1); y high after bit 5.
REQ-029 Stream 1,0,[din_vld=0 for 3 cycles, din toggling],0,1 -> match detected exactly once; state frozen during the stall.
REQ-030 Stream 1,0,0 then reset=1 for 1 cycle, then 1 -> y stays 0, state=1 after the final bit, match_cnt=0.
REQ-031 CNT_W=2, PATTERN=2'b11, OVERLAP=1, six accepted 1s -> y high on 5 consecutive cycles; match_cnt saturates at 3.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: the state is the KMP match depth, and y is a registered Moore flag.
// Define SEQ_DETECT_CNT_EN to build the saturating match counter behind match_cnt.
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1001,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_vld,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SW = $clog2(N + 1);
  localparam logic [SW-1:0] FULL = SW'(N);

  // Next depth after bit b at depth k: the longest prefix of PATTERN that is a suffix of (prefix k, b).
  function automatic int kmpNext(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    if (k == N && OVERLAP == 0) begin
      return (b == PATTERN[N-1]) ? 1 : 0;
    end
    best = 0;
    for (int len = 1; len <= N; len++) begin
      if (len <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          idx = k + 1 - len + j;
          if (idx == k) sb = b;
          else          sb = PATTERN[N-1-idx];
          if (sb != PATTERN[N-1-j]) ok = 1'b0;
        end
        if (ok) best = len;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] nxt0 [N+1];
  logic [SW-1:0] nxt1 [N+1];

  for (genvar g = 0; g <= N; g++) begin : g_tbl
    localparam int NXT0 = kmpNext(g, 1'b0);
    localparam int NXT1 = kmpNext(g, 1'b1);
    assign nxt0[g] = SW'(NXT0);
    assign nxt1[g] = SW'(NXT1);
  end

  logic [SW-1:0] depth_q, depth_d;
  logic          y_q;

  always_comb begin
    depth_d = depth_q;
    if (depth_q > FULL) begin
      depth_d = '0;
    end else if (din_vld) begin
      for (int k = 0; k <= N; k++) begin
        if (depth_q == SW'(k)) depth_d = din ? nxt1[k] : nxt0[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      y_q     <= 1'b0;
    end else begin
      depth_q <= depth_d;
      y_q     <= (depth_d == FULL);
    end
  end

  assign y = y_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Every accepted bit that lands in depth N is a completed match, including N -> N overlaps.
  always_comb begin
    cnt_d = cnt_q;
    if (din_vld && (depth_q <= FULL) && (depth_d == FULL) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param: default, non-overlapping and short saturating configurations.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       yA, yB, yC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;
  int         testsRun = 0;
  int         failCount = 0;

  seq_detect_param dutA (
    .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .y(yA), .match_cnt(cntA)
  );

  seq_detect_param #(.OVERLAP(0)) dutB (
    .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .y(yB), .match_cnt(cntB)
  );

  seq_detect_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) dutC (
    .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .y(yC), .match_cnt(cntC)
  );

  always #5 clk = ~clk;

  // Expected counter value depends on whether the counter is built
  function automatic logic [31:0] expCnt(input int c);
`ifdef SEQ_DETECT_CNT_EN
    return 32'(c);
`else
    return 32'(c - c);
`endif
  endfunction

  // Drive inputs mid-cycle, then advance past the next rising edge so outputs are settled
  task automatic applyStimulus(input logic r, input logic b, input logic v);
    @(negedge clk);
    reset   = r;
    din     = b;
    din_vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [6:0] s1Bits;
    logic [6:0] s1YA;
    logic [6:0] s1YB;
    logic [4:0] s2Bits;
    logic [4:0] s2Y;

    // Scenario 1: 1,0,0,1,0,0,1 on the default and non-overlapping detectors
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_yA", 32'(yA), 32'd0);
    checkOutput("reset_cntA", 32'(cntA), expCnt(0));
    checkOutput("reset_yB", 32'(yB), 32'd0);
    checkOutput("reset_cntC", 32'(cntC), expCnt(0));
    s1Bits = 7'b1001001;
    s1YA   = 7'b0001001;
    s1YB   = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(1'b0, s1Bits[i], 1'b1);
      checkOutput($sformatf("s1_yA_bit%0d", 7 - i), 32'(yA), 32'(s1YA[i]));
      checkOutput($sformatf("s1_yB_bit%0d", 7 - i), 32'(yB), 32'(s1YB[i]));
    end
    checkOutput("s1_cntA", 32'(cntA), expCnt(2));
    checkOutput("s1_cntB", 32'(cntB), expCnt(1));

    // Scenario 2: 1,1,0,0,1 keeps the partial match on the repeated 1
    applyStimulus(1'b1, 1'b0, 1'b1);
    s2Bits = 5'b11001;
    s2Y    = 5'b00001;
    for (int i = 4; i >= 0; i--) begin
      applyStimulus(1'b0, s2Bits[i], 1'b1);
      checkOutput($sformatf("s2_yA_bit%0d", 5 - i), 32'(yA), 32'(s2Y[i]));
    end
    checkOutput("s2_cntA", 32'(cntA), expCnt(1));

    // Scenario 3: stall mid-pattern with din toggling, then finish the pattern and stall in N
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s3_stall_yA", 32'(yA), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s3_bit3_yA", 32'(yA), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s3_bit4_yA", 32'(yA), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s3_hold_yA", 32'(yA), 32'd1);
    checkOutput("s3_cntA", 32'(cntA), expCnt(1));

    // Scenario 4: reset mid-pattern must discard the accepted 1,0,0
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("s4_rst_yA", 32'(yA), 32'd0);
    checkOutput("s4_rst_cntA", 32'(cntA), expCnt(0));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s4_after1_yA", 32'(yA), 32'd0);
    checkOutput("s4_after1_cntA", 32'(cntA), expCnt(0));
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s4_depth3_yA", 32'(yA), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s4_match_yA", 32'(yA), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("s4_rstN_yA", 32'(yA), 32'd0);
    checkOutput("s4_rstN_cntA", 32'(cntA), expCnt(0));

    // Scenario 5: pattern 11 with a two-bit counter over six consecutive 1s
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("s5_yC_bit%0d", i), 32'(yC), (i >= 2) ? 32'd1 : 32'd0);
      checkOutput($sformatf("s5_cntC_bit%0d", i), 32'(cntC), expCnt((i - 1 > 3) ? 3 : i - 1));
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s5_break_yC", 32'(yC), 32'd0);
    checkOutput("s5_break_cntC", 32'(cntC), expCnt(3));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
